// File: rtl/hvsync_if.sv
// hvsync_if: video timing bundle carried from hvsync_generator to the pixel
// pipeline (counters plus the registered sync/status flags, all co-timed).
interface hvsync_if;
  logic [8:0] hpos;
  logic [8:0] vpos;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic       line_start;
  logic       frame_start;

  modport master (
    output hpos, vpos, hsync, vsync, display_on, line_start, frame_start
  );

  modport slave (
    input  hpos, vpos, hsync, vsync, display_on, line_start, frame_start
  );
endinterface

// File: rtl/hvsync_generator.sv
// hvsync_generator: free-running video timing for a 256x240 visible raster
// on a 309x262 total raster. Every output is registered on the same edge, and
// the status flags are decoded from the *next* counter values, so they line up
// with the hpos/vpos visible in the same cycle.
//
// Build option: define HVSYNC_CE_EN to add the `ce` pixel-enable port, for use
// on a full-rate clock. Without it every clk edge is a pixel step.
module hvsync_generator #(
  parameter int H_DISPLAY = 256,
  parameter int H_FRONT   = 7,
  parameter int H_SYNC    = 23,
  parameter int H_BACK    = 23,
  parameter int V_DISPLAY = 240,
  parameter int V_BOTTOM  = 14,
  parameter int V_SYNC    = 3,
  parameter int V_TOP     = 5
) (
  input  logic     clk,
  input  logic     reset,
`ifdef HVSYNC_CE_EN
  input  logic     ce,
`endif
  hvsync_if.master vid
);

  localparam int H_MAX_I        = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
  localparam int H_SYNC_START_I = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END_I   = H_SYNC_START_I + H_SYNC - 1;
  localparam int V_MAX_I        = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;
  localparam int V_SYNC_START_I = V_DISPLAY + V_BOTTOM;
  localparam int V_SYNC_END_I   = V_SYNC_START_I + V_SYNC - 1;

  // Counters are 9 bits wide; larger rasters cannot be represented.
  generate
    if (H_MAX_I > 511 || V_MAX_I > 511) begin : g_range_chk
      $error("hvsync_generator: H_MAX/V_MAX exceed the 9-bit counter range");
    end
  endgenerate

  localparam logic [8:0] H_MAX        = 9'(H_MAX_I);
  localparam logic [8:0] H_SYNC_START = 9'(H_SYNC_START_I);
  localparam logic [8:0] H_SYNC_END   = 9'(H_SYNC_END_I);
  localparam logic [8:0] H_DISP       = 9'(H_DISPLAY);
  localparam logic [8:0] V_MAX        = 9'(V_MAX_I);
  localparam logic [8:0] V_SYNC_START = 9'(V_SYNC_START_I);
  localparam logic [8:0] V_SYNC_END   = 9'(V_SYNC_END_I);
  localparam logic [8:0] V_DISP       = 9'(V_DISPLAY);

  logic [8:0] hpos_q, vpos_q;
  logic [8:0] h_nxt, v_nxt;
  logic       hs_q, vs_q, de_q, ls_q, fs_q;
  logic       hs_nxt, vs_nxt, de_nxt, ls_nxt, fs_nxt;
  logic       h_wrap;
  logic       step;

  // Pixel step qualifier: ce when the enable build is selected, else always.
  always_comb begin
`ifdef HVSYNC_CE_EN
    step = ce;
`else
    step = 1'b1;
`endif
  end

  // Next counter values and the flags decoded from them.
  always_comb begin
    h_wrap = (hpos_q == H_MAX);
    h_nxt  = h_wrap ? 9'd0 : hpos_q + 9'd1;
    v_nxt  = vpos_q;
    if (h_wrap)
      v_nxt = (vpos_q == V_MAX) ? 9'd0 : vpos_q + 9'd1;
    hs_nxt = (h_nxt >= H_SYNC_START) && (h_nxt <= H_SYNC_END);
    vs_nxt = (v_nxt >= V_SYNC_START) && (v_nxt <= V_SYNC_END);
    de_nxt = (h_nxt < H_DISP) && (v_nxt < V_DISP);
    ls_nxt = (h_nxt == 9'd0);
    fs_nxt = (h_nxt == 9'd0) && (v_nxt == 9'd0);
  end

  // Counter and flag registers; reset wins over the step enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_q <= 9'd0;
      vpos_q <= 9'd0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      de_q   <= 1'b1;
      ls_q   <= 1'b1;
      fs_q   <= 1'b1;
    end else if (step) begin
      hpos_q <= h_nxt;
      vpos_q <= v_nxt;
      hs_q   <= hs_nxt;
      vs_q   <= vs_nxt;
      de_q   <= de_nxt;
      ls_q   <= ls_nxt;
      fs_q   <= fs_nxt;
    end
  end

  assign vid.hpos        = hpos_q;
  assign vid.vpos        = vpos_q;
  assign vid.hsync       = hs_q;
  assign vid.vsync       = vs_q;
  assign vid.display_on  = de_q;
  assign vid.line_start  = ls_q;
  assign vid.frame_start = fs_q;

endmodule

// File: tb/tb_hvsync_generator.sv
// tb_hvsync_generator: checks the timing generator against a step-count model
// (position = step index mod line/frame length), plus literal expectations.
// A second instance is used for the mid-frame reset so that both scenarios
// share one pass through the frame.
module tb_hvsync_generator;

  localparam int LINE  = 309;
  localparam int LINES = 262;
  localparam int FRAME = LINE * LINES; // 80958

  typedef struct packed {
    logic [8:0] h;
    logic [8:0] v;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset2 = 1'b1;
  logic ce_tb = 1'b1;
  bit   chk_en = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   n1 = 0;
  int   n2 = 0;

  hvsync_if vid1 ();
  hvsync_if vid2 ();

  hvsync_generator dut (
    .clk   (clk),
    .reset (reset),
`ifdef HVSYNC_CE_EN
    .ce    (ce_tb),
`endif
    .vid   (vid1)
  );

  hvsync_generator dut2 (
    .clk   (clk),
    .reset (reset2),
`ifdef HVSYNC_CE_EN
    .ce    (ce_tb),
`endif
    .vid   (vid2)
  );

  always #5 clk = ~clk;

  // Expected outputs for the n-th step after reset.
  function automatic obs_t model(input int n);
    obs_t m;
    int h, v;
    h = n % LINE;
    v = (n / LINE) % LINES;
    m.h  = 9'(h);
    m.v  = 9'(v);
    m.hs = (h >= 263) && (h <= 285);
    m.vs = (v >= 254) && (v <= 256);
    m.de = (h < 256) && (v < 240);
    m.ls = (h == 0);
    m.fs = (h == 0) && (v == 0);
    return m;
  endfunction

  // Step counters of the model.
  always @(posedge clk) begin
    if (reset) n1 <= 0;
    else if (ce_tb) n1 <= (n1 + 1) % FRAME;
    if (reset2) n2 <= 0;
    else if (ce_tb) n2 <= (n2 + 1) % FRAME;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    obs_t a, e;
    if (chk_en) begin
      a = {vid1.hpos, vid1.vpos, vid1.hsync, vid1.vsync, vid1.display_on,
           vid1.line_start, vid1.frame_start};
      e = model(n1);
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL model_dut1 t=%0t got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b want h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                 $time, a.h, a.v, a.hs, a.vs, a.de, a.ls, a.fs,
                 e.h, e.v, e.hs, e.vs, e.de, e.ls, e.fs);
      end
      a = {vid2.hpos, vid2.vpos, vid2.hsync, vid2.vsync, vid2.display_on,
           vid2.line_start, vid2.frame_start};
      e = model(n2);
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL model_dut2 t=%0t got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b want h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                 $time, a.h, a.v, a.hs, a.vs, a.de, a.ls, a.fs,
                 e.h, e.v, e.hs, e.vs, e.de, e.ls, e.fs);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag, input bit second);
    if (!second) begin
      chk({tag, "_hpos"}, 32'(vid1.hpos), 0);
      chk({tag, "_vpos"}, 32'(vid1.vpos), 0);
      chk({tag, "_hsync"}, 32'(vid1.hsync), 0);
      chk({tag, "_vsync"}, 32'(vid1.vsync), 0);
      chk({tag, "_de"}, 32'(vid1.display_on), 1);
      chk({tag, "_ls"}, 32'(vid1.line_start), 1);
      chk({tag, "_fs"}, 32'(vid1.frame_start), 1);
    end else begin
      chk({tag, "_hpos"}, 32'(vid2.hpos), 0);
      chk({tag, "_vpos"}, 32'(vid2.vpos), 0);
      chk({tag, "_hsync"}, 32'(vid2.hsync), 0);
      chk({tag, "_vsync"}, 32'(vid2.vsync), 0);
      chk({tag, "_de"}, 32'(vid2.display_on), 1);
      chk({tag, "_ls"}, 32'(vid2.line_start), 1);
      chk({tag, "_fs"}, 32'(vid2.frame_start), 1);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;
    reset2 = 1'b0;

    fork
      // Primary instance: reset from a random state, then one full frame.
      begin
        int hs_cnt, hs_first, hs_last, ls_cnt, fs_cnt, vs_cnt;
        int vs_first, vs_last, last_ls, gap_bad;
        repeat ($urandom_range(50, 700)) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk_reset_vals("rst_hold", 1'b0);
        end
        reset = 1'b0;
        hs_cnt = 0; hs_first = -1; hs_last = -1; ls_cnt = 0; fs_cnt = 0;
        vs_cnt = 0; vs_first = -1; vs_last = -1; last_ls = 0; gap_bad = 0;
        for (int k = 1; k <= FRAME; k++) begin
          @(negedge clk);
          if (k == 255) chk("de_at_255", 32'(vid1.display_on), 1);
          if (k == 256) chk("de_drop_256", 32'(vid1.display_on), 0);
          if (k == 308) begin
            chk("lwrap_pre_h", 32'(vid1.hpos), 308);
            chk("lwrap_pre_v", 32'(vid1.vpos), 0);
          end
          if (k == 309) begin
            chk("lwrap_h", 32'(vid1.hpos), 0);
            chk("lwrap_v", 32'(vid1.vpos), 1);
            chk("lwrap_ls", 32'(vid1.line_start), 1);
          end
          if (k >= 309 && k <= 617 && vid1.hsync === 1'b1) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(vid1.hpos);
            hs_last = int'(vid1.hpos);
          end
          if (vid1.line_start === 1'b1) begin
            ls_cnt++;
            if (k - last_ls != LINE) gap_bad++;
            last_ls = k;
          end
          if (vid1.frame_start === 1'b1) fs_cnt++;
          if (vid1.vsync === 1'b1) begin
            vs_cnt++;
            if (vs_first < 0) vs_first = int'(vid1.vpos);
            vs_last = int'(vid1.vpos);
          end
          if (k == FRAME - 1) begin
            chk("fwrap_pre_h", 32'(vid1.hpos), 308);
            chk("fwrap_pre_v", 32'(vid1.vpos), 261);
          end
          if (k == FRAME) begin
            chk("fwrap_h", 32'(vid1.hpos), 0);
            chk("fwrap_v", 32'(vid1.vpos), 0);
            chk("fwrap_fs", 32'(vid1.frame_start), 1);
          end
        end
        chk("hsync_steps", 32'(hs_cnt), 23);
        chk("hsync_first", 32'(hs_first), 263);
        chk("hsync_last", 32'(hs_last), 285);
        chk("ls_per_frame", 32'(ls_cnt), 262);
        chk("ls_gap_bad", 32'(gap_bad), 0);
        chk("fs_per_frame", 32'(fs_cnt), 1);
        chk("vsync_steps", 32'(vs_cnt), 927);
        chk("vsync_first_v", 32'(vs_first), 254);
        chk("vsync_last_v", 32'(vs_last), 256);
      end
      // Second instance: one-clock reset at vpos=100, hpos=150.
      begin
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40000 && !found; i++) begin
          @(negedge clk);
          if (vid2.hpos === 9'd150 && vid2.vpos === 9'd100) found = 1'b1;
        end
        chk("mid_reached", 32'(found), 1);
        if (found) begin
          reset2 = 1'b1;
          @(negedge clk);
          chk_reset_vals("mid_rst", 1'b1);
          reset2 = 1'b0;
          @(negedge clk);
          chk("mid_resume_h", 32'(vid2.hpos), 1);
          chk("mid_resume_v", 32'(vid2.vpos), 0);
          chk("mid_resume_ls", 32'(vid2.line_start), 0);
        end
      end
    join

`ifdef HVSYNC_CE_EN
    begin
      obs_t prev;
      int line_clk;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      line_clk = 0;
      for (int c = 1; c <= 700; c++) begin
        ce_tb = (c % 2 == 0);
        prev = {vid1.hpos, vid1.vpos, vid1.hsync, vid1.vsync, vid1.display_on,
                vid1.line_start, vid1.frame_start};
        @(negedge clk);
        if (!ce_tb)
          chk("ce_hold", 32'({vid1.hpos, vid1.vpos, vid1.hsync, vid1.vsync,
                              vid1.display_on, vid1.line_start, vid1.frame_start}),
              32'(prev));
        if (line_clk == 0 && vid1.vpos === 9'd1 && vid1.hpos === 9'd0) line_clk = c;
      end
      chk("ce_line_clocks", 32'(line_clk), 618);
      ce_tb = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("ce_rst", 1'b0);
      reset = 1'b0;
      ce_tb = 1'b1;
      @(negedge clk);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
